// File: rtl/hyperbus_ca_serializer_pkg.sv
// hyperbus_pkg: CA word layout constants, serializer state encoding and the CA word builder
package hyperbus_pkg;
    localparam int CA_W = 48;
    localparam int CA_RW_BIT = 47;
    localparam int CA_AS_BIT = 46;
    localparam int CA_BT_BIT = 45;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, WAIT_DONE = 2'd2} ca_state_e;
    function automatic logic [CA_W-1:0] build_ca(input logic rw, input logic asp, input logic bt, input logic [31:0] addr);
        logic [CA_W-1:0] ca;
        ca = '0;
        ca[CA_RW_BIT] = rw;
        ca[CA_AS_BIT] = asp;
        ca[CA_BT_BIT] = bt;
        ca[44:16] = addr[31:3];
        ca[2:0] = addr[2:0];
        return ca;
    endfunction
endpackage

// File: rtl/hyperbus_ca_if.sv
// hyperbus_ca_if: request handshake, PHY beat stream, chip selects and txn control; slave = serializer, master = controller/PHY side
interface hyperbus_ca_if #(parameter int BUS_W = 8, parameter int NUM_CS = 2);
    localparam int BEAT_W = 2 * BUS_W;
    localparam int CS_SEL_W = NUM_CS > 1 ? $clog2(NUM_CS) : 1;
    logic req_valid_i;
    logic req_ready_o;
    logic rw_i;
    logic address_space_i;
    logic burst_type_i;
    logic [31:0] address_i;
    logic [CS_SEL_W-1:0] cs_sel_i;
    logic ca_valid_o;
    logic ca_ready_i;
    logic [BEAT_W-1:0] ca_data_o;
    logic ca_last_o;
    logic [NUM_CS-1:0] cs_o;
    logic txn_done_i;
    logic abort_i;
    logic busy_o;
    modport slave (
        input req_valid_i, rw_i, address_space_i, burst_type_i, address_i, cs_sel_i, ca_ready_i, txn_done_i, abort_i,
        output req_ready_o, ca_valid_o, ca_data_o, ca_last_o, cs_o, busy_o
    );
    modport master (
        output req_valid_i, rw_i, address_space_i, burst_type_i, address_i, cs_sel_i, ca_ready_i, txn_done_i, abort_i,
        input req_ready_o, ca_valid_o, ca_data_o, ca_last_o, cs_o, busy_o
    );
endinterface

// File: rtl/hyperbus_ca_serializer.sv
// hyperbus_ca_serializer: accepts a request (clk_i, rst_i, bus), builds the 48-bit CA word, streams it MSB-first as PHY beats and holds one-hot CS until done/abort
module hyperbus_ca_serializer
    import hyperbus_pkg::*;
#(
    parameter int BUS_W = 8,
    parameter int NUM_CS = 2
) (
    input logic clk_i,
    input logic rst_i,
    hyperbus_ca_if.slave bus
);
    localparam int BEAT_W = 2 * BUS_W;
    localparam int NUM_BEATS = (CA_W + BEAT_W - 1) / BEAT_W;
    localparam int SH_W = NUM_BEATS * BEAT_W;
    localparam int CNT_W = $clog2(NUM_BEATS);
    localparam int CS_SEL_W = NUM_CS > 1 ? $clog2(NUM_CS) : 1;
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_WAIT = WAIT_DONE;
    logic [1:0] state;
    logic [CNT_W-1:0] beat_cnt;
    logic [SH_W-1:0] sh;
    logic [NUM_CS-1:0] cs;
    logic [CS_SEL_W-1:0] sel;
    logic accept, last, active;
    assign active = state != ST_IDLE;
    assign accept = bus.req_ready_o && bus.req_valid_i;
    assign last = beat_cnt == CNT_W'(NUM_BEATS - 1);
    assign sel = {1'b0, bus.cs_sel_i} < (CS_SEL_W + 1)'(NUM_CS) ? bus.cs_sel_i : '0;
    always_comb begin
        bus.req_ready_o = state == ST_IDLE && !rst_i;
        bus.ca_valid_o = state == ST_SHIFT;
        bus.ca_last_o = state == ST_SHIFT && last;
        bus.ca_data_o = state == ST_SHIFT ? sh[SH_W-1 -: BEAT_W] : '0;
        bus.cs_o = cs;
        bus.busy_o = active;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            beat_cnt <= '0;
            sh <= '0;
            cs <= '0;
        end else if (active && bus.abort_i) begin
            state <= ST_IDLE;
            beat_cnt <= '0;
            cs <= '0;
        end else if (accept) begin
            state <= ST_SHIFT;
            beat_cnt <= '0;
            sh <= SH_W'(build_ca(bus.rw_i, bus.address_space_i, bus.burst_type_i, bus.address_i)) << (SH_W - CA_W);
            cs <= NUM_CS'(1) << sel;
        end else if (state == ST_SHIFT && bus.ca_ready_i) begin
            state <= last ? ST_WAIT : ST_SHIFT;
            beat_cnt <= last ? '0 : beat_cnt + CNT_W'(1);
            sh <= sh << BEAT_W;
        end else if (state == ST_WAIT && bus.txn_done_i) begin
            state <= ST_IDLE;
            cs <= '0;
        end
    end
endmodule

// File: tb/tb_hyperbus_ca_serializer.sv
// tb_hyperbus_ca_serializer: x8 (2 CS) and x16 (3 CS) serializers driven in lockstep against an arithmetic CA model
module tb_hyperbus_ca_serializer;
    logic clk, rst;
    logic req_valid, rw, asp, bt, ca_ready, txn_done, abort;
    logic [31:0] addr;
    logic [1:0] cs_sel;
    int checks = 0;
    int errors = 0;
    hyperbus_ca_if #(.BUS_W(8), .NUM_CS(2)) if8 ();
    hyperbus_ca_if #(.BUS_W(16), .NUM_CS(3)) if16 ();
    assign if8.req_valid_i = req_valid;
    assign if8.rw_i = rw;
    assign if8.address_space_i = asp;
    assign if8.burst_type_i = bt;
    assign if8.address_i = addr;
    assign if8.cs_sel_i = cs_sel[0];
    assign if8.ca_ready_i = ca_ready;
    assign if8.txn_done_i = txn_done;
    assign if8.abort_i = abort;
    assign if16.req_valid_i = req_valid;
    assign if16.rw_i = rw;
    assign if16.address_space_i = asp;
    assign if16.burst_type_i = bt;
    assign if16.address_i = addr;
    assign if16.cs_sel_i = cs_sel;
    assign if16.ca_ready_i = ca_ready;
    assign if16.txn_done_i = txn_done;
    assign if16.abort_i = abort;
    hyperbus_ca_serializer #(.BUS_W(8), .NUM_CS(2)) dut8 (.clk_i(clk), .rst_i(rst), .bus(if8.slave));
    hyperbus_ca_serializer #(.BUS_W(16), .NUM_CS(3)) dut16 (.clk_i(clk), .rst_i(rst), .bus(if16.slave));
    initial clk = 0;
    always #5 clk = ~clk;
    function automatic logic [47:0] model_ca(input logic r, input logic a, input logic b, input logic [31:0] ad);
        return (48'(r) << 47) | (48'(a) << 46) | (48'(b) << 45) | (48'(ad / 8) << 16) | 48'(ad % 8);
    endfunction
    function automatic logic [15:0] beat8(input logic [47:0] ca, input int k);
        return 16'(ca >> (32 - 16 * k));
    endfunction
    function automatic logic [31:0] beat16(input logic [47:0] ca, input int k);
        logic [63:0] padded;
        padded = {ca, 16'h0};
        return 32'(padded >> (32 - 32 * k));
    endfunction
    function automatic logic [2:0] oh16(input logic [1:0] s);
        return 3'(1) << (s < 3 ? s : 2'd0);
    endfunction
    task automatic test_reset;
        rst = 1;
        {req_valid, rw, asp, bt, ca_ready, txn_done, abort, addr, cs_sel} = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({if8.req_ready_o, if8.ca_valid_o, if8.ca_last_o, if8.ca_data_o, if8.cs_o, if8.busy_o} !== 22'h0) begin
            errors++;
            $display("FAIL reset8 got rdy=%b v=%b l=%b d=%h cs=%b busy=%b want all zero", if8.req_ready_o, if8.ca_valid_o, if8.ca_last_o, if8.ca_data_o, if8.cs_o, if8.busy_o);
        end
        checks++;
        if ({if16.req_ready_o, if16.ca_valid_o, if16.ca_last_o, if16.ca_data_o, if16.cs_o, if16.busy_o} !== 39'h0) begin
            errors++;
            $display("FAIL reset16 got rdy=%b v=%b l=%b d=%h cs=%b busy=%b want all zero", if16.req_ready_o, if16.ca_valid_o, if16.ca_last_o, if16.ca_data_o, if16.cs_o, if16.busy_o);
        end
        rst = 0;
        @(negedge clk);
        checks++;
        if ({if8.req_ready_o, if8.busy_o, if16.req_ready_o, if16.busy_o} !== 4'b1010) begin
            errors++;
            $display("FAIL reset_release got rdy8=%b busy8=%b rdy16=%b busy16=%b want 1 0 1 0", if8.req_ready_o, if8.busy_o, if16.req_ready_o, if16.busy_o);
        end
    endtask
    task automatic test_directed;
        logic [15:0] lit8 [3] = '{16'hA000, 16'h0246, 16'h0005};
        logic [31:0] lit16 [2] = '{32'hA000_0246, 32'h0005_0000};
        {rw, asp, bt, addr, cs_sel} = {1'b1, 1'b0, 1'b1, 32'h0000_1235, 2'd1};
        req_valid = 1;
        ca_ready = 1;
        @(negedge clk);
        req_valid = 0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({if8.ca_valid_o, if8.ca_last_o, if8.ca_data_o, if8.cs_o} !== {1'b1, c == 2, lit8[c], 2'b10}) begin
                errors++;
                $display("FAIL directed8 beat %0d got v=%b l=%b d=%h cs=%b want v=1 l=%b d=%h cs=10", c, if8.ca_valid_o, if8.ca_last_o, if8.ca_data_o, if8.cs_o, c == 2, lit8[c]);
            end
            checks++;
            if (c < 2 ? {if16.ca_valid_o, if16.ca_last_o, if16.ca_data_o, if16.cs_o} !== {1'b1, c == 1, lit16[c], 3'b010}
                      : {if16.ca_valid_o, if16.cs_o} !== 4'b0010) begin
                errors++;
                $display("FAIL directed16 cycle %0d got v=%b l=%b d=%h cs=%b want v=%b l=%b d=%h cs=010", c, if16.ca_valid_o, if16.ca_last_o, if16.ca_data_o, if16.cs_o, c < 2, c == 1, c < 2 ? lit16[c] : 32'h0);
            end
            @(negedge clk);
        end
        ca_ready = 0;
        checks++;
        if ({if8.ca_valid_o, if8.cs_o, if8.busy_o, if16.ca_valid_o, if16.cs_o, if16.busy_o} !== {1'b0, 2'b10, 1'b1, 1'b0, 3'b010, 1'b1}) begin
            errors++;
            $display("FAIL directed_wait got v8=%b cs8=%b busy8=%b v16=%b cs16=%b busy16=%b want 0 10 1 0 010 1", if8.ca_valid_o, if8.cs_o, if8.busy_o, if16.ca_valid_o, if16.cs_o, if16.busy_o);
        end
        txn_done = 1;
        @(negedge clk);
        txn_done = 0;
        checks++;
        if ({if8.cs_o, if8.busy_o, if8.req_ready_o, if16.cs_o, if16.busy_o, if16.req_ready_o} !== {2'b00, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL directed_done got cs8=%b busy8=%b rdy8=%b cs16=%b busy16=%b rdy16=%b want 00 0 1 000 0 1", if8.cs_o, if8.busy_o, if8.req_ready_o, if16.cs_o, if16.busy_o, if16.req_ready_o);
        end
    endtask
    task automatic run_txn(input logic r, input logic a, input logic b, input logic [31:0] ad, input logic [1:0] s, input int mode);
        logic [47:0] ca;
        logic [1:0] e_oh8;
        logic [2:0] e_oh16;
        logic [20:0] e8, o8;
        logic [37:0] e16, o16;
        int k8, k16, cyc, stall, n;
        logic rd;
        ca = model_ca(r, a, b, ad);
        e_oh8 = 2'(1) << s[0];
        e_oh16 = oh16(s);
        checks++;
        if ({if8.req_ready_o, if16.req_ready_o} !== 2'b11) begin
            errors++;
            $display("FAIL txn_ready got rdy8=%b rdy16=%b want 1 1", if8.req_ready_o, if16.req_ready_o);
        end
        {rw, asp, bt, addr, cs_sel} = {r, a, b, ad, s};
        req_valid = 1;
        @(negedge clk);
        req_valid = 0;
        k8 = 0;
        k16 = 0;
        cyc = 0;
        stall = 0;
        while ((k8 < 3 || k16 < 2) && cyc < 200) begin
            e8 = k8 < 3 ? {1'b1, k8 == 2, beat8(ca, k8), e_oh8, 1'b1} : {2'b00, 16'h0, e_oh8, 1'b1};
            o8 = {if8.ca_valid_o, if8.ca_last_o, if8.ca_valid_o ? if8.ca_data_o : 16'h0, if8.cs_o, if8.busy_o};
            e16 = k16 < 2 ? {1'b1, k16 == 1, beat16(ca, k16), e_oh16, 1'b1} : {2'b00, 32'h0, e_oh16, 1'b1};
            o16 = {if16.ca_valid_o, if16.ca_last_o, if16.ca_valid_o ? if16.ca_data_o : 32'h0, if16.cs_o, if16.busy_o};
            checks++;
            if (o8 !== e8) begin
                errors++;
                $display("FAIL beat8 k=%0d got {v,l,d,cs,busy}=%h want %h", k8, o8, e8);
            end
            checks++;
            if (o16 !== e16) begin
                errors++;
                $display("FAIL beat16 k=%0d got {v,l,d,cs,busy}=%h want %h", k16, o16, e16);
            end
            rd = mode == 0 ? 1'b1 : mode == 1 ? $urandom_range(0, 2) != 0 : !(k8 == 1 && stall < 3);
            if (!rd) stall++;
            ca_ready = rd;
            @(negedge clk);
            if (rd) begin
                if (k8 < 3) k8++;
                if (k16 < 2) k16++;
            end
            cyc++;
        end
        ca_ready = 0;
        checks++;
        if (cyc >= 200 || (mode == 0 && cyc != 3) || (mode == 2 && cyc != 6)) begin
            errors++;
            $display("FAIL beat_cycles got %0d want %0d", cyc, mode == 2 ? 6 : 3);
        end
        n = $urandom_range(0, 3);
        for (int i = 0; i <= n; i++) begin
            checks++;
            if ({if8.ca_valid_o, if8.cs_o, if8.busy_o, if16.ca_valid_o, if16.cs_o, if16.busy_o} !== {1'b0, e_oh8, 1'b1, 1'b0, e_oh16, 1'b1}) begin
                errors++;
                $display("FAIL wait_done got v8=%b cs8=%b busy8=%b v16=%b cs16=%b busy16=%b want 0 %b 1 0 %b 1", if8.ca_valid_o, if8.cs_o, if8.busy_o, if16.ca_valid_o, if16.cs_o, if16.busy_o, e_oh8, e_oh16);
            end
            if (i == n) txn_done = 1;
            @(negedge clk);
        end
        txn_done = 0;
        checks++;
        if ({if8.cs_o, if8.busy_o, if8.req_ready_o, if16.cs_o, if16.busy_o, if16.req_ready_o} !== {2'b00, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL txn_release got cs8=%b busy8=%b rdy8=%b cs16=%b busy16=%b rdy16=%b want 00 0 1 000 0 1", if8.cs_o, if8.busy_o, if8.req_ready_o, if16.cs_o, if16.busy_o, if16.req_ready_o);
        end
    endtask
    task automatic test_stall;
        run_txn(1'b1, 1'b0, 1'b1, 32'h0000_1235, 2'd1, 2);
    endtask
    task automatic test_write_reg;
        run_txn(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 2'd0, 0);
        run_txn(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 2'd3, 0);
    endtask
    task automatic test_abort;
        {rw, asp, bt, addr, cs_sel} = {1'b1, 1'b0, 1'b1, 32'h0000_1235, 2'd2};
        req_valid = 1;
        ca_ready = 1;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0;
        ca_ready = 0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({if8.ca_valid_o, if8.cs_o, if8.busy_o, if8.req_ready_o, if16.ca_valid_o, if16.cs_o, if16.busy_o, if16.req_ready_o} !== {1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL abort_idle %0d got v8=%b cs8=%b busy8=%b rdy8=%b v16=%b cs16=%b busy16=%b rdy16=%b want 0 00 0 1 0 000 0 1", i, if8.ca_valid_o, if8.cs_o, if8.busy_o, if8.req_ready_o, if16.ca_valid_o, if16.cs_o, if16.busy_o, if16.req_ready_o);
            end
            @(negedge clk);
        end
        abort = 1;
        req_valid = 1;
        @(negedge clk);
        abort = 0;
        req_valid = 0;
        txn_done = 1;
        checks++;
        if ({if8.ca_valid_o, if8.ca_data_o, if8.cs_o, if16.ca_valid_o, if16.cs_o} !== {1'b1, 16'hA000, 2'b01, 1'b1, 3'b100}) begin
            errors++;
            $display("FAIL abort_in_idle got v8=%b d8=%h cs8=%b v16=%b cs16=%b want 1 a000 01 1 100", if8.ca_valid_o, if8.ca_data_o, if8.cs_o, if16.ca_valid_o, if16.cs_o);
        end
        @(negedge clk);
        txn_done = 0;
        checks++;
        if ({if8.ca_valid_o, if8.ca_data_o, if8.busy_o, if16.ca_valid_o, if16.ca_data_o, if16.busy_o} !== {1'b1, 16'hA000, 1'b1, 1'b1, 32'hA000_0246, 1'b1}) begin
            errors++;
            $display("FAIL done_ignored got v8=%b d8=%h busy8=%b v16=%b d16=%h busy16=%b want 1 a000 1 1 a0000246 1", if8.ca_valid_o, if8.ca_data_o, if8.busy_o, if16.ca_valid_o, if16.ca_data_o, if16.busy_o);
        end
        abort = 1;
        @(negedge clk);
        abort = 0;
        checks++;
        if ({if8.busy_o, if8.cs_o, if16.busy_o, if16.cs_o} !== 7'b0) begin
            errors++;
            $display("FAIL abort_shift got busy8=%b cs8=%b busy16=%b cs16=%b want all zero", if8.busy_o, if8.cs_o, if16.busy_o, if16.cs_o);
        end
    endtask
    task automatic test_back_to_back;
        {rw, asp, bt, addr, cs_sel} = {1'b0, 1'b0, 1'b1, 32'h1234_5678, 2'd1};
        req_valid = 1;
        @(negedge clk);
        req_valid = 0;
        ca_ready = 1;
        repeat (3) @(negedge clk);
        ca_ready = 0;
        {rw, asp, bt, addr, cs_sel} = {1'b1, 1'b1, 1'b1, 32'h0000_0008, 2'd0};
        txn_done = 1;
        req_valid = 1;
        @(negedge clk);
        txn_done = 0;
        checks++;
        if ({if8.cs_o, if8.busy_o, if8.req_ready_o, if16.cs_o, if16.busy_o, if16.req_ready_o} !== {2'b00, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL b2b_gap got cs8=%b busy8=%b rdy8=%b cs16=%b busy16=%b rdy16=%b want 00 0 1 000 0 1", if8.cs_o, if8.busy_o, if8.req_ready_o, if16.cs_o, if16.busy_o, if16.req_ready_o);
        end
        @(negedge clk);
        req_valid = 0;
        checks++;
        if ({if8.ca_valid_o, if8.ca_data_o, if8.cs_o, if16.ca_valid_o, if16.ca_data_o, if16.cs_o} !== {1'b1, beat8(model_ca(1, 1, 1, 32'h8), 0), 2'b01, 1'b1, beat16(model_ca(1, 1, 1, 32'h8), 0), 3'b001}) begin
            errors++;
            $display("FAIL b2b_accept got v8=%b d8=%h cs8=%b v16=%b d16=%h cs16=%b want 1 e000 01 1 e0000001 001", if8.ca_valid_o, if8.ca_data_o, if8.cs_o, if16.ca_valid_o, if16.ca_data_o, if16.cs_o);
        end
        ca_ready = 1;
        repeat (3) @(negedge clk);
        ca_ready = 0;
        rst = 1;
        req_valid = 1;
        @(negedge clk);
        checks++;
        if ({if8.req_ready_o, if8.ca_valid_o, if8.ca_last_o, if8.ca_data_o, if8.cs_o, if8.busy_o, if16.req_ready_o, if16.ca_valid_o, if16.ca_last_o, if16.ca_data_o, if16.cs_o, if16.busy_o} !== 61'h0) begin
            errors++;
            $display("FAIL reset_mid got rdy8=%b v8=%b cs8=%b busy8=%b rdy16=%b v16=%b cs16=%b busy16=%b want all zero", if8.req_ready_o, if8.ca_valid_o, if8.cs_o, if8.busy_o, if16.req_ready_o, if16.ca_valid_o, if16.cs_o, if16.busy_o);
        end
        rst = 0;
        @(negedge clk);
        req_valid = 0;
        checks++;
        if ({if8.busy_o, if8.ca_valid_o, if8.cs_o, if16.busy_o, if16.ca_valid_o, if16.cs_o} !== {1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 3'b001}) begin
            errors++;
            $display("FAIL reset_reaccept got busy8=%b v8=%b cs8=%b busy16=%b v16=%b cs16=%b want 1 1 01 1 1 001", if8.busy_o, if8.ca_valid_o, if8.cs_o, if16.busy_o, if16.ca_valid_o, if16.cs_o);
        end
        abort = 1;
        @(negedge clk);
        abort = 0;
    endtask
    task automatic test_random;
        repeat (30) run_txn(1'($urandom), 1'($urandom), 1'($urandom), $urandom, 2'($urandom_range(0, 3)), 1);
    endtask
    initial begin
        test_reset;
        test_directed;
        test_stall;
        test_write_reg;
        test_abort;
        test_back_to_back;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
